fdct_1d_serial: RTL and testbench



---
 rtl/fdct_1d_serial_if.sv | 25 ++
 rtl/fdct_1d_serial.sv | 137 +++++++++++++
 tb/tb_fdct_1d_serial.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fdct_1d_serial_if.sv
// Stream bundle for the serial 1-D FDCT: sample input channel and coefficient output channel.
// Master drives samples and out_ready; slave (the transform) drives the rest.
interface fdct_1d_serial_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [2:0]               out_index;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fdct_1d_serial.sv
// 8-point forward 1-D DCT: buffers 8 samples, then emits X[0..7] serially (FDCT_CLAMP_EN saturates to [-2048,2047]).
// Latency: 8th input accept at cycle t -> X[0] valid at t+2; one coefficient per output handshake.
// Backpressure: no overlap; in_ready=0 while emitting, outputs held while out_valid && !out_ready.
module fdct_1d_serial #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 13
) (
    input logic               clk,
    input logic               rst,
    fdct_1d_serial_if.slave   bus
);
    localparam int ACC_W = DATA_W + 16;

    typedef enum logic [1:0] {COLLECT, LOAD, EMIT} state_t;

    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]  out_data_q, out_data_d;
    logic [2:0]               out_index_q, out_index_d;
    logic signed [DATA_W-1:0] samp_q [8];
    logic                     wr_en;
    logic [2:0]               k_sel;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rnd;
    logic signed [OUT_W-1:0]  coef;

    // cos(i*pi/16) scaled by 4096 for i = 0..8
    function automatic logic signed [13:0] cval(input logic [3:0] i);
        case (i)
            4'd0:    return 14'sd4096;
            4'd1:    return 14'sd4017;
            4'd2:    return 14'sd3784;
            4'd3:    return 14'sd3406;
            4'd4:    return 14'sd2896;
            4'd5:    return 14'sd2276;
            4'd6:    return 14'sd1567;
            4'd7:    return 14'sd799;
            default: return 14'sd0;
        endcase
    endfunction

    // T[k][n]: fold (2n+1)k mod 32 into the first quadrant; row 0 carries the 1/sqrt(2) factor as C4
    function automatic logic signed [13:0] tcoef(input logic [2:0] k, input logic [2:0] n);
        logic [6:0] p;
        logic [4:0] m;
        if (k == 3'd0) return 14'sd2896;
        p = 7'({n, 1'b1}) * 7'(k);
        m = p[4:0];
        if (m <= 5'd8)       return cval(m[3:0]);
        else if (m <= 5'd16) return -cval(4'(5'd16 - m));
        else if (m <= 5'd24) return -cval(4'(m - 5'd16));
        else                 return cval(4'(6'd32 - 6'(m)));
    endfunction

    assign k_sel = (state_q == EMIT) ? out_index_q + 3'd1 : 3'd0;

    always_comb begin
        acc = '0;
        for (int n = 0; n < 8; n++) begin
            acc = acc + ACC_W'(samp_q[n]) * ACC_W'(tcoef(k_sel, 3'(n)));
        end
        rnd = (acc + ACC_W'(1 << (SHIFT - 1))) >>> SHIFT;
`ifdef FDCT_CLAMP_EN
        if (rnd > ACC_W'(2047))       coef = OUT_W'(2047);
        else if (rnd < -ACC_W'(2048)) coef = -OUT_W'(2048);
        else                          coef = OUT_W'(rnd);
`else
        coef = OUT_W'(rnd);
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        wr_en       = 1'b0;
        case (state_q)
            COLLECT: begin
                if (bus.in_valid && in_ready_q) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d  = coef;
                out_index_d = 3'd0;
                out_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_index_q == 3'd7) begin
                        out_valid_d = 1'b0;
                        state_d     = COLLECT;
                    end else begin
                        out_data_d  = coef;
                        out_index_d = out_index_q + 3'd1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        in_ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            for (int i = 0; i < 8; i++) samp_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            if (wr_en) samp_q[cnt_q] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_valid_q && (out_index_q == 3'd7);
endmodule

// File: tb/tb_fdct_1d_serial.sv
// Directed bench for fdct_1d_serial: vector table plus backpressure and reset sequences.
// Golden coefficients come from hand values and a real-cosine model.
module tb_fdct_1d_serial;
    localparam int DATA_W = 16;
    localparam int OUT_W  = 32;
    localparam int SHIFT  = 13;
    localparam int NVEC   = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fdct_1d_serial_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    fdct_1d_serial #(.DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int     x[8];
        longint exp[8];
    } vec_t;

    vec_t  tbl[NVEC];
    string nm[NVEC];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic int tval(input int k, input int n);
        real v;
        if (k == 0) return 2896;
        v = 4096.0 * $cos(3.14159265358979323846 * real'((2 * n + 1) * k) / 16.0);
        return int'(v);
    endfunction

    function automatic longint model(input int x[8], input int k);
        longint acc;
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(x[n]) * longint'(tval(k, n));
        acc = (acc + 64'sd4096) >>> 13;
`ifdef FDCT_CLAMP_EN
        if (acc > 2047) acc = 2047;
        if (acc < -2048) acc = -2048;
`endif
        return acc;
    endfunction

    task automatic send_n(input string name, input int x[8], input int cnt, output bit ok);
        int w;
        ok = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            bus.in_data  = DATA_W'(x[i]);
            bus.in_valid = 1'b1;
            w = 0;
            while (!bus.in_ready && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (!bus.in_ready) begin
                timeout({name, "_in_ready"});
                ok = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_vec(input string name, input longint exp[8], input int stall_at);
        int w;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 0;
            while (!bus.out_valid && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (!bus.out_valid) begin
                timeout($sformatf("%s_valid%0d", name, i));
                return;
            end
            check($sformatf("%s_idx%0d", name, i), bus.out_index, i);
            check($sformatf("%s_last%0d", name, i), bus.out_last, (i == 7) ? 1 : 0);
            check($sformatf("%s_data%0d", name, i), bus.out_data, exp[i]);
            if (i == stall_at) begin
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                bus.in_data   = DATA_W'(1234);
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s_hold_data%0d", name, s), bus.out_data, exp[i]);
                    check($sformatf("%s_hold_idx%0d", name, s), bus.out_index, i);
                    check($sformatf("%s_hold_vld%0d", name, s), bus.out_valid, 1);
                    check($sformatf("%s_hold_rdy%0d", name, s), bus.in_ready, 0);
                end
                bus.in_valid  = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        check({name, "_done_vld"}, bus.out_valid, 0);
    endtask

    task automatic run_vec(input string name, input int x[8], input longint exp[8], input int stall_at);
        bit ok;
        send_n(name, x, 8, ok);
        if (!ok) return;
        check({name, "_load_vld"}, bus.out_valid, 0);
        check({name, "_load_rdy"}, bus.in_ready, 0);
        @(posedge clk); #1;
        check({name, "_lat_vld"}, bus.out_valid, 1);
        recv_vec(name, exp, stall_at);
    endtask

    initial begin
        int     dc[8];
        int     part[8];
        longint dc_exp[8];
        bit     ok;
        int     w;

        dc     = '{100, 100, 100, 100, 100, 100, 100, 100};
        dc_exp = '{283, 0, 0, 0, 0, 0, 0, 0};
        part   = '{500, 500, 500, 500, 0, 0, 0, 0};

        nm[0] = "dc";    tbl[0].x = dc; tbl[0].exp = dc_exp;
        nm[1] = "negdc"; tbl[1].x = '{-100, -100, -100, -100, -100, -100, -100, -100};
        tbl[1].exp = '{-283, 0, 0, 0, 0, 0, 0, 0};
        nm[2] = "imp";   tbl[2].x = '{1000, 0, 0, 0, 0, 0, 0, 0};
        nm[3] = "ramp";  tbl[3].x = '{-300, -200, -100, 0, 100, 200, 300, 400};
        nm[4] = "alt";   tbl[4].x = '{500, -500, 500, -500, 500, -500, 500, -500};
        for (int k = 0; k < 8; k++) begin
            tbl[2].exp[k] = model(tbl[2].x, k);
            tbl[3].exp[k] = model(tbl[3].x, k);
            tbl[4].exp[k] = model(tbl[4].x, k);
        end
        nm[5] = "sat";   tbl[5].x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
`ifdef FDCT_CLAMP_EN
        tbl[5].exp = '{2047, 0, 0, 0, 0, 0, 0, 0};
`else
        tbl[5].exp = '{92669, 0, 0, 0, 0, 0, 0, 0};
`endif

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last", bus.out_last, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_rdy", bus.in_ready, 1);

        check("imp_model_x0", tbl[2].exp[0], 354);
        check("imp_model_x1", tbl[2].exp[1], 490);

        for (int v = 0; v < NVEC; v++) run_vec(nm[v], tbl[v].x, tbl[v].exp, -1);

        // stall mid-vector with in_valid asserted, then a clean DC vector
        run_vec("bp", tbl[3].x, tbl[3].exp, 3);
        run_vec("bp_next", dc, dc_exp, -1);

        // reset after a partial vector; sample presented alongside reset must be dropped
        send_n("part", part, 4, ok);
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(999);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstc_in_ready", bus.in_ready, 0);
        check("rstc_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        run_vec("rstc_dc", dc, dc_exp, -1);

        // reset while emitting
        send_n("rste", dc, 8, ok);
        bus.out_ready = 1'b1;
        w = 0;
        while (!(bus.out_valid && bus.out_index == 3'd2) && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!(bus.out_valid && bus.out_index == 3'd2)) timeout("rste_idx2");
        rst = 1'b1;
        @(posedge clk); #1;
        check("rste_out_valid", bus.out_valid, 0);
        check("rste_out_data", bus.out_data, 0);
        check("rste_out_index", bus.out_index, 0);
        check("rste_out_last", bus.out_last, 0);
        check("rste_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rste_release_rdy", bus.in_ready, 1);
        run_vec("rste_dc", tbl[1].x, tbl[1].exp, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
